// File: rtl/can_frame_tail_ctrl_pkg.sv
// Shared types and constants for the CAN receive-side frame-tail sequencer.
package can_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CRC_DEL,
      ACK_SLOT,
      ACK_DEL,
      EOF,
      INTERMISSION,
      ERROR_WAIT
   } tail_state_e;

   localparam logic RECESSIVE = 1'b1;
   localparam logic DOMINANT  = 1'b0;

   localparam int unsigned CAN_EOF_BITS          = 7;
   localparam int unsigned CAN_INTERMISSION_BITS = 3;
   localparam int unsigned CAN_IDLE_RUN          = 11;

endpackage

// File: rtl/can_frame_tail_ctrl_bit_counter.sv
// Bit-time counter: synchronous clear, increment, saturation at MAX_VAL.
module can_bit_counter #(
   parameter int unsigned W       = 4,
   parameter int unsigned MAX_VAL = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   localparam logic [W-1:0] CNT_MAX = W'(MAX_VAL);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/can_frame_tail_ctrl.sv
// CAN frame-tail sequencer: CRC/ACK delimiters, ACK slot, EOF, intermission, error idle wait.
// Define CAN_TAIL_STATS_EN to add saturating Frame_Cnt / Err_Cnt outputs.
module can_frame_tail_ctrl
   import can_pkg::*;
#(
   parameter int unsigned EOF_BITS          = CAN_EOF_BITS,
   parameter int unsigned INTERMISSION_BITS = CAN_INTERMISSION_BITS,
   parameter int unsigned IDLE_RUN          = CAN_IDLE_RUN,
   parameter int unsigned CNT_W             = 4
) (
   input  logic       SP,
   input  logic       reset,
   input  logic       RX,
   input  logic       CRC_Done,
   input  logic       EOF_Error,
   output logic       EOF_Flag,
   output logic       Form_Error,
   output logic       Ack_Missing,
   output logic       Overload_Req,
   output logic       Frame_Done,
   output logic       Error_Out,
   output logic       Busy
`ifdef CAN_TAIL_STATS_EN
  ,output logic [7:0] Frame_Cnt,
   output logic [7:0] Err_Cnt
`endif
);

   localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
   localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INTERMISSION_BITS - 1);

   tail_state_e      state_d, state_q;
   logic             cnt_clr, cnt_inc, cnt_at_max;
   logic [CNT_W-1:0] cnt;

   logic eof_flag_d, form_error_d, ack_missing_d, overload_req_d, frame_done_d, error_out_d, busy_d;
   logic eof_flag_q, form_error_q, ack_missing_q, overload_req_q, frame_done_q, error_out_q, busy_q;

   can_bit_counter #(
      .W       (CNT_W),
      .MAX_VAL (IDLE_RUN - 1)
   ) u_bit_counter (
      .clk    (SP),
      .reset  (reset),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .cnt    (cnt),
      .at_max (cnt_at_max)
   );

   always_comb begin
      state_d        = state_q;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      eof_flag_d     = 1'b0;
      form_error_d   = 1'b0;
      ack_missing_d  = 1'b0;
      overload_req_d = 1'b0;
      frame_done_d   = 1'b0;
      error_out_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (CRC_Done) state_d = CRC_DEL;
         end
         CRC_DEL: begin
            if (RX == RECESSIVE) begin
               state_d = ACK_SLOT;
            end else begin
               form_error_d = 1'b1;
               error_out_d  = 1'b1;
               cnt_clr      = 1'b1;
               state_d      = ERROR_WAIT;
            end
         end
         ACK_SLOT: begin
            ack_missing_d = (RX == RECESSIVE);
            state_d       = ACK_DEL;
         end
         ACK_DEL: begin
            cnt_clr = 1'b1;
            if (RX == RECESSIVE) begin
               eof_flag_d = 1'b1;
               state_d    = EOF;
            end else begin
               form_error_d = 1'b1;
               error_out_d  = 1'b1;
               state_d      = ERROR_WAIT;
            end
         end
         EOF: begin
            // RX is not inspected here; the EOF error block reports bit errors.
            cnt_inc = 1'b1;
            if (EOF_Error) begin
               error_out_d = 1'b1;
               cnt_clr     = 1'b1;
               state_d     = ERROR_WAIT;
            end else if (cnt == EOF_LAST) begin
               cnt_clr = 1'b1;
               state_d = INTERMISSION;
            end
         end
         INTERMISSION: begin
            cnt_inc = 1'b1;
            if (cnt == INT_LAST) begin
               frame_done_d = 1'b1;
               cnt_clr      = 1'b1;
               state_d      = IDLE;
            end else if (RX == DOMINANT) begin
               overload_req_d = 1'b1;
               cnt_clr        = 1'b1;
               state_d        = IDLE;
            end
         end
         ERROR_WAIT: begin
            if (RX == RECESSIVE) begin
               cnt_inc = 1'b1;
               if (cnt_at_max) begin
                  cnt_clr = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge SP) begin
      if (reset) begin
         state_q        <= IDLE;
         eof_flag_q     <= 1'b0;
         form_error_q   <= 1'b0;
         ack_missing_q  <= 1'b0;
         overload_req_q <= 1'b0;
         frame_done_q   <= 1'b0;
         error_out_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         eof_flag_q     <= eof_flag_d;
         form_error_q   <= form_error_d;
         ack_missing_q  <= ack_missing_d;
         overload_req_q <= overload_req_d;
         frame_done_q   <= frame_done_d;
         error_out_q    <= error_out_d;
         busy_q         <= busy_d;
      end
   end

   assign EOF_Flag     = eof_flag_q;
   assign Form_Error   = form_error_q;
   assign Ack_Missing  = ack_missing_q;
   assign Overload_Req = overload_req_q;
   assign Frame_Done   = frame_done_q;
   assign Error_Out    = error_out_q;
   assign Busy         = busy_q;

`ifdef CAN_TAIL_STATS_EN
   logic [7:0] frame_cnt_d, frame_cnt_q, err_cnt_d, err_cnt_q;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (frame_done_d && (frame_cnt_q != 8'hFF)) frame_cnt_d = frame_cnt_q + 8'd1;
      if (error_out_d && (err_cnt_q != 8'hFF))    err_cnt_d   = err_cnt_q + 8'd1;
   end

   always_ff @(posedge SP) begin
      if (reset) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign Frame_Cnt = frame_cnt_q;
   assign Err_Cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_can_frame_tail_ctrl.sv
// Directed, table-driven bench for can_frame_tail_ctrl (stats checks under CAN_TAIL_STATS_EN).
module tb_can_frame_tail_ctrl;

   logic SP = 1'b0;
   logic reset = 1'b1, RX = 1'b1, CRC_Done = 1'b0, EOF_Error = 1'b0;
   logic EOF_Flag, Form_Error, Ack_Missing, Overload_Req, Frame_Done, Error_Out, Busy;
`ifdef CAN_TAIL_STATS_EN
   logic [7:0] Frame_Cnt, Err_Cnt;
`endif

   can_frame_tail_ctrl dut (
      .SP           (SP),
      .reset        (reset),
      .RX           (RX),
      .CRC_Done     (CRC_Done),
      .EOF_Error    (EOF_Error),
      .EOF_Flag     (EOF_Flag),
      .Form_Error   (Form_Error),
      .Ack_Missing  (Ack_Missing),
      .Overload_Req (Overload_Req),
      .Frame_Done   (Frame_Done),
      .Error_Out    (Error_Out),
      .Busy         (Busy)
`ifdef CAN_TAIL_STATS_EN
     ,.Frame_Cnt    (Frame_Cnt),
      .Err_Cnt      (Err_Cnt)
`endif
   );

   always #5 SP = ~SP;

   // Output vector order: {EOF_Flag, Form_Error, Ack_Missing, Overload_Req, Frame_Done, Error_Out, Busy}
   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_BUSY = 7'b0000001;
   localparam logic [6:0] O_EOFF = 7'b1000001;
   localparam logic [6:0] O_ACKM = 7'b0010001;
   localparam logic [6:0] O_OVL  = 7'b0001000;
   localparam logic [6:0] O_DONE = 7'b0000100;
   localparam logic [6:0] O_FERR = 7'b0100011;
   localparam logic [6:0] O_EERR = 7'b0000011;

   typedef struct packed {
      logic       rst;
      logic       rx;
      logic       crc;
      logic       eerr;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [6:0] outs();
      return {EOF_Flag, Form_Error, Ack_Missing, Overload_Req, Frame_Done, Error_Out, Busy};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic x, input logic c, input logic e);
      reset     = r;
      RX        = x;
      CRC_Done  = c;
      EOF_Error = e;
      @(posedge SP);
      #1;
   endtask

   task automatic add(input logic r, input logic x, input logic c, input logic e, input logic [6:0] ex);
      vec_t v;
      v.rst = r; v.rx = x; v.crc = c; v.eerr = e; v.exp = ex;
      vecs.push_back(v);
   endtask

   task automatic add_head(input logic ack_rx);
      add(0, 1, 1, 0, O_BUSY);
      add(0, 1, 0, 0, O_BUSY);
      add(0, ack_rx, 0, 0, ack_rx ? O_ACKM : O_BUSY);
      add(0, 1, 0, 0, O_EOFF);
   endtask

   task automatic add_eof7();
      for (int i = 0; i < 7; i++) add(0, (i != 4), (i == 2), 0, O_BUSY);
   endtask

   task automatic add_wait11();
      for (int i = 0; i < 10; i++) add(0, 1, 0, 0, O_BUSY);
      add(0, 1, 0, 0, O_NONE);
   endtask

   task automatic run_clean_frame();
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
      step(0, 1, 0, 0);
   endtask

   initial begin
      int cyc;
      int eof_at;

      // reset (CRC_Done held high must not matter) and idle behaviour
      add(1, 1, 0, 0, O_NONE);
      add(1, 1, 1, 0, O_NONE);
      add(0, 1, 0, 1, O_NONE);
      add(0, 0, 0, 0, O_NONE);
      // clean tail
      add_head(0); add_eof7();
      add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_DONE);
      add(0, 1, 0, 0, O_NONE);
      // ack missing, frame still completes
      add_head(1); add_eof7();
      add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_DONE);
      // overload in intermission bit 2, then bit 1
      add_head(0); add_eof7();
      add(0, 1, 0, 0, O_BUSY); add(0, 0, 0, 0, O_OVL); add(0, 1, 0, 0, O_NONE);
      add_head(0); add_eof7();
      add(0, 0, 0, 0, O_OVL);
      // dominant on final intermission bit counts as completion
      add_head(0); add_eof7();
      add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY); add(0, 0, 0, 0, O_DONE);
      // CRC delimiter form error
      add(0, 1, 1, 0, O_BUSY); add(0, 0, 0, 0, O_FERR); add_wait11();
      // ACK delimiter form error
      add(0, 1, 1, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY); add(0, 0, 0, 0, O_BUSY);
      add(0, 0, 0, 0, O_FERR); add_wait11();
      // EOF error on 4th EOF edge; dominant after 5 recessive restarts idle count
      add_head(0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, O_BUSY);
      add(0, 1, 0, 1, O_EERR);
      for (int i = 0; i < 5; i++) add(0, 1, (i == 2), (i == 2), O_BUSY);
      add(0, 0, 0, 0, O_BUSY);
      add_wait11();
      // EOF error on the final EOF edge beats the transition to intermission
      add_head(0);
      for (int i = 0; i < 6; i++) add(0, 1, 0, 0, O_BUSY);
      add(0, 1, 0, 1, O_EERR);
      add_wait11();
      // reset on ACK delimiter suppresses EOF_Flag
      add(0, 1, 1, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY); add(0, 0, 0, 0, O_BUSY);
      add(1, 1, 0, 0, O_NONE); add(0, 1, 0, 0, O_NONE);
      // reset during EOF bit 3, then a fresh tail
      add_head(0);
      add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY);
      add(1, 1, 0, 0, O_NONE); add(0, 1, 0, 0, O_NONE);
      add_head(0); add_eof7();
      add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_BUSY); add(0, 1, 0, 0, O_DONE);
      add(0, 1, 0, 0, O_NONE);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].rx, vecs[i].crc, vecs[i].eerr);
         chk($sformatf("row%0d", i), 32'(outs()), 32'(vecs[i].exp));
      end

      // Latency from CRC_Done edge to EOF_Flag and Frame_Done
      step(0, 1, 1, 0);
      cyc    = 0;
      eof_at = -1;
      while (cyc < 40) begin
         step(0, (cyc == 1) ? 1'b0 : 1'b1, 0, 0);
         cyc++;
         if (EOF_Flag) eof_at = cyc;
         if (Frame_Done) break;
      end
      chk("eof_flag_latency", 32'(eof_at), 32'd3);
      chk("frame_done_latency", 32'(cyc), 32'd13);
      step(0, 1, 0, 0);
      chk("frame_done_one_cycle", 32'(outs()), 32'(O_NONE));

`ifdef CAN_TAIL_STATS_EN
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("stats_reset_frame", 32'(Frame_Cnt), 32'd0);
      chk("stats_reset_err", 32'(Err_Cnt), 32'd0);
      for (int f = 0; f < 3; f++) run_clean_frame();
      step(0, 1, 1, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
      chk("stats_frame_cnt3", 32'(Frame_Cnt), 32'd3);
      chk("stats_err_cnt1", 32'(Err_Cnt), 32'd1);
      for (int f = 0; f < 300; f++) run_clean_frame();
      chk("stats_frame_sat", 32'(Frame_Cnt), 32'd255);
      chk("stats_err_hold", 32'(Err_Cnt), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
